// File: rtl/irq_nest_ctrl.sv
// Nested interrupt controller: edge/level ISR capture, per-depth masks,
// return-address stack and a registered trap handshake FSM.
module irq_nest_ctrl #(
  parameter int IRQ_COUNT  = 32,
  parameter int DEPTH_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IRQ_COUNT-1:0] irq,
  input  logic                 strobe,
  input  logic                 rw,
  input  logic [3:0]           addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 rvalid,
  output logic                 trap,
  output logic [4:0]           vector,
  input  logic                 ack,
  output logic                 halt,
  output logic                 err
);

  localparam int N = IRQ_COUNT;
  localparam int MAX_DEPTH = 2**DEPTH_BITS;

  typedef enum logic [1:0] {
    IDLE,
    TRAP,
    WAIT
  } state_t;

  state_t state;

  logic [N-1:0] isr;
  logic [N-1:0] mode;
  logic [N-1:0] irq_q;
  logic [N-1:0] imr [MAX_DEPTH];
  logic [31:0]  ret [MAX_DEPTH];
  logic [DEPTH_BITS-1:0] depth;

  logic wr_req;
  logic rd_req;
  logic wr_isr;
  logic wr_imr;
  logic wr_mode;
  logic wr_ctrl;
  logic push;
  logic pop;
  logic at_top;
  logic at_bot;
  logic [DEPTH_BITS-1:0] up;
  logic [DEPTH_BITS-1:0] dn;
  logic [N-1:0] wmask;
  logic [N-1:0] clr;
  logic [N-1:0] rise;
  logic [N-1:0] pending;
  logic [4:0]   first;
  logic [31:0]  rmux;

  assign wr_req  = strobe & rw;
  assign rd_req  = strobe & ~rw;
  assign wr_isr  = wr_req && addr == 4'h0;
  assign wr_imr  = wr_req && addr == 4'h1;
  assign push    = wr_req && addr == 4'h2;
  assign wr_mode = wr_req && addr == 4'h3;
  assign wr_ctrl = wr_req && addr == 4'hF;
  assign pop     = rd_req && addr == 4'h2;

  assign at_top = depth == DEPTH_BITS'(MAX_DEPTH - 1);
  assign at_bot = depth == '0;
  assign up     = depth + DEPTH_BITS'(1);
  assign dn     = depth - DEPTH_BITS'(1);

  assign wmask   = wdata[N-1:0];
  assign clr     = wr_isr ? wmask : '0;
  assign rise    = irq & ~irq_q;
  assign pending = isr & imr[depth];

  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    first = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) first = 5'(i);
    end
  end

  always_comb begin
    rmux = '0;
    case (addr)
      4'h0:    rmux = 32'(isr);
      4'h1:    rmux = 32'(imr[depth]);
      4'h2:    rmux = at_bot ? '0 : ret[depth];
      4'h3:    rmux = 32'(mode);
      4'h4:    rmux = 32'(depth);
      4'h5:    rmux = 32'(vector);
      4'hF:    rmux = {30'b0, err, halt};
      default: rmux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      isr    <= '0;
      mode   <= '0;
      irq_q  <= '0;
      depth  <= '0;
      trap   <= 1'b0;
      vector <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
      halt   <= 1'b0;
      err    <= 1'b0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
        imr[i] <= '0;
        ret[i] <= '0;
      end
    end else begin
      irq_q <= irq;
      // Edge bits: a new edge beats a same-cycle clear. Level bits follow irq_q.
      isr <= (mode & ((isr & ~clr) | rise)) | (~mode & irq_q);

      if (wr_mode) mode <= wmask;
      if (wr_imr) imr[depth] <= wmask;

      if (push) begin
        if (at_top) begin
          err <= 1'b1;
        end else begin
          ret[up] <= wdata;
          imr[up] <= '0;
          depth   <= up;
        end
      end

      if (pop) begin
        if (at_bot) err <= 1'b1;
        else        depth <= dn;
      end

      if (wr_ctrl) begin
        halt <= wdata[0];
        if (wdata[1]) err <= 1'b0;
      end

      rvalid <= rd_req;
      rdata  <= rd_req ? rmux : '0;

      case (state)
        IDLE: begin
          if (|pending) begin
            state  <= TRAP;
            trap   <= 1'b1;
            vector <= first;
          end
        end
        TRAP: begin
          if (ack) begin
            state <= WAIT;
            trap  <= 1'b0;
          end
        end
        WAIT: begin
          if (push) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          trap  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_nest_ctrl.sv
// Scoreboard bench for irq_nest_ctrl: reads and trap vectors are queued
// at issue time and checked by a negedge monitor.
module tb_irq_nest_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  irq = '0;
  logic        strobe = 1'b0;
  logic        rw = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        trap;
  logic [4:0]  vector;
  logic        ack = 1'b0;
  logic        halt;
  logic        err;

  irq_nest_ctrl #(
    .IRQ_COUNT (8),
    .DEPTH_BITS(2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .irq    (irq),
    .strobe (strobe),
    .rw     (rw),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .rvalid (rvalid),
    .trap   (trap),
    .vector (vector),
    .ack    (ack),
    .halt   (halt),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rexp_t;

  rexp_t       rq[$];
  logic [4:0]  tq[$];
  rexp_t       re;
  logic [4:0]  tv;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        trap_prev = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rvalid) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected: got rdata 0x%0h expected none", rdata);
      end else begin
        re = rq.pop_front();
        chk("rdata", rdata, re.data);
        chk("rvalid_latency", cyc, re.due);
      end
    end
    if (trap && !trap_prev) begin
      if (tq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL trap_unexpected: got vector %0d expected none", vector);
      end else begin
        tv = tq.pop_front();
        chk("trap_vector", vector, tv);
      end
    end
    trap_prev = trap;
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    strobe = 1'b1;
    rw = 1'b1;
    addr = a;
    wdata = d;
    @(negedge clk);
    strobe = 1'b0;
    rw = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    strobe = 1'b1;
    rw = 1'b0;
    addr = a;
    rq.push_back('{e, cyc + 1});
    @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic wait_trap(input string name, input int lim);
    for (int i = 0; i < lim && !trap; i++) @(negedge clk);
    chk(name, trap, 1);
  endtask

  task automatic pulse(input logic [7:0] v);
    irq = v;
    @(negedge clk);
    irq = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_trap", trap, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_err", err, 0);
    chk("rst_halt", halt, 0);
    chk("rst_vector", vector, 0);
    chk("rst_rdata", rdata, 0);
    reset_n = 1'b1;
    rd(4'h4, 0);
    rd(4'h1, 0);
    rd(4'h3, 0);

    // single edge irq, trap hold, ack with concurrent read
    wr(4'h3, 32'hFF);
    wr(4'h1, 32'h4);
    tq.push_back(5'd2);
    pulse(8'h04);
    wait_trap("t41_trap", 3);
    repeat (3) begin
      chk("t41_hold", trap, 1);
      chk("t41_vec", vector, 2);
      @(negedge clk);
    end
    ack = 1'b1;
    rd(4'h5, 2);
    ack = 1'b0;
    chk("t41_trap_clr", trap, 0);
    rd(4'h4, 0);
    wr(4'h0, 32'h4);
    wr(4'h2, 32'h100);
    rd(4'h2, 32'h100);
    rd(4'h0, 0);
    chk("t41_idle", trap, 0);

    // priority, nested re-trap at depth 1, upper bits read 0
    wr(4'h1, 32'hFFFF_FFFF);
    rd(4'h1, 32'hFF);
    tq.push_back(5'd1);
    pulse(8'h22);
    wait_trap("t42_trap1", 3);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    wr(4'h0, 32'h2);
    tq.push_back(5'd5);
    wr(4'h2, 32'hAAAA);
    rd(4'h1, 0);
    chk("t42_masked", trap, 0);
    wr(4'h1, 32'hFF);
    wait_trap("t42_trap2", 3);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    wr(4'h0, 32'h20);
    wr(4'h2, 32'h0);
    rd(4'h2, 0);
    rd(4'h2, 32'hAAAA);
    rd(4'h1, 32'hFF);
    rd(4'h4, 0);

    // return stack order and mask restore
    wr(4'h2, 32'h1234);
    wr(4'h2, 32'h5678);
    rd(4'h4, 2);
    rd(4'h2, 32'h5678);
    rd(4'h2, 32'h1234);
    rd(4'h1, 32'hFF);
    rd(4'h4, 0);

    // overflow, halt/err control, underflow
    rd(4'hF, 0);
    wr(4'h2, 32'h11);
    wr(4'h2, 32'h22);
    wr(4'h2, 32'h33);
    wr(4'h2, 32'h44);
    rd(4'h4, 3);
    chk("t44_err_ovf", err, 1);
    rd(4'hF, 2);
    wr(4'hF, 1);
    chk("t44_halt", halt, 1);
    rd(4'hF, 3);
    wr(4'hF, 2);
    chk("t44_err_clr", err, 0);
    chk("t44_halt_clr", halt, 0);
    rd(4'h2, 32'h33);
    rd(4'h2, 32'h22);
    rd(4'h2, 32'h11);
    rd(4'h4, 0);
    chk("t44_err_still0", err, 0);
    rd(4'h2, 0);
    chk("t44_err_unf", err, 1);
    rd(4'h4, 0);
    wr(4'hF, 2);
    rd(4'h6, 0);

    // edge set beats same-cycle W1C
    wr(4'h1, 0);
    irq = 8'h08;
    wr(4'h0, 32'h8);
    irq = '0;
    rd(4'h0, 32'h8);
    wr(4'h0, 32'h8);
    rd(4'h0, 0);

    // level mode bit0
    wr(4'h3, 32'hFE);
    irq = 8'h01;
    repeat (2) @(negedge clk);
    rd(4'h0, 1);
    wr(4'h0, 1);
    rd(4'h0, 1);
    irq = '0;
    rd(4'h0, 1);
    rd(4'h0, 1);
    rd(4'h0, 0);

    // reset while trapped and mid-read
    wr(4'h3, 32'hFF);
    rd(4'h2, 0);
    chk("t46_err_set", err, 1);
    wr(4'h1, 32'h10);
    tq.push_back(5'd4);
    pulse(8'h10);
    wait_trap("t46_trap", 3);
    wr(4'h2, 32'h99);
    chk("t46_hold_masked", trap, 1);
    chk("t46_vec_masked", vector, 4);
    rd(4'h4, 1);
    reset_n = 1'b0;
    strobe = 1'b1;
    rw = 1'b0;
    addr = 4'h4;
    @(negedge clk);
    strobe = 1'b0;
    chk("t46_trap_rst", trap, 0);
    chk("t46_err_rst", err, 0);
    chk("t46_rvalid_rst", rvalid, 0);
    reset_n = 1'b1;
    rd(4'h4, 0);
    rd(4'h1, 0);
    repeat (5) @(negedge clk);
    chk("t46_no_trap", trap, 0);

    chk("rq_drained", rq.size(), 0);
    chk("tq_drained", tq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_nest_ctrl.md
IRQ_NEST_CTRL -- requirements
Module: irq_nest_ctrl

Interface
REQ-001 The block SHALL have parameter IRQ_COUNT, default 32, meaning number of interrupt lines (1..32).
REQ-002 The block SHALL have parameter DEPTH_BITS, default 4, meaning log2 of the nesting depth; MAX_DEPTH = 2**DEPTH_BITS.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock, all logic on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: the reset, synchronous, active-low.
REQ-005 The block SHALL have port irq, input, IRQ_COUNT bits: the interrupt request lines, synchronous to clk.
REQ-006 The block SHALL have port strobe, input, 1 bit: the register access request.
REQ-007 The block SHALL have port rw, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have port addr, input, 4 bits: the register word offset.
REQ-009 The block SHALL have port wdata, input, 32 bits: the write data.
REQ-010 The block SHALL have port rdata, output, 32 bits: the read data, valid when rvalid=1.
REQ-011 The block SHALL have port rvalid, output, 1 bit: the read data valid flag.
REQ-012 The block SHALL have port trap, output, 1 bit: the interrupt request to the core.
REQ-013 The block SHALL have port vector, output, 5 bits: the index of the IRQ being signalled.
REQ-014 The block SHALL have port ack, input, 1 bit: the core accepts the trap.
REQ-015 The block SHALL have port halt, output, 1 bit: the core halt control.
REQ-016 The block SHALL have port err, output, 1 bit: the sticky stack overflow/underflow flag.

Function
REQ-017 The register map SHALL be: 0 ISR (R; W1C), 1 IMR (R/W; current-depth mask, 1 = enabled), 2 RA (W = push, R = pop), 3 MODE (R/W; 1 = edge, 0 = level), 4 DEPTH (R), 5 VEC (R), 0xF CTRL (bit0 halt R/W, bit1 err R/W1C); other offsets SHALL read 0 and ignore writes.
REQ-018 Reads SHALL have 1-cycle latency: rvalid=1 with rdata in the cycle after a strobe with rw=0, otherwise rvalid=0; bits above IRQ_COUNT SHALL read 0.
REQ-019 Edge-mode bits SHALL capture a rising edge versus irq registered one cycle earlier; the ISR bit SHALL then set and hold until W1C.
REQ-020 Level-mode bits SHALL load the registered irq every cycle, and W1C SHALL have no lasting effect on them.
REQ-021 If a new edge and a W1C hit the same ISR bit in the same cycle, set SHALL win.
REQ-022 pending = ISR & IMR[depth]; vector = lowest-index set bit of pending.
REQ-023 The trap FSM SHALL have states IDLE, TRAP, and WAIT; all transitions SHALL be registered.
REQ-024 IDLE->TRAP: when pending != 0; trap=1 and vector latched in the same transition.
REQ-025 TRAP: trap SHALL hold 1 and vector SHALL be stable until ack=1.
REQ-026 TRAP->WAIT: on ack; trap=0 next cycle.
REQ-027 WAIT->IDLE: on the next RA push, so a trap is never re-raised before the handler masks.
REQ-028 While in WAIT, VEC SHALL hold the acknowledged vector.
REQ-029 In TRAP, pending becoming 0 (mask or clear) SHALL NOT drop trap before ack; the latched vector is delivered.
REQ-030 RA push (write offset 2) SHALL store wdata in ret[depth+1], set IMR[depth+1]=0, and increment depth, effective next cycle.
REQ-031 RA pop (read offset 2) SHALL return ret[depth], decrement depth, and restore the mask to IMR[depth-1].
REQ-032 A push at depth == MAX_DEPTH-1 SHALL be ignored, with err set.
REQ-033 A pop at depth == 0 SHALL return 0 with depth unchanged, with err set.
REQ-034 IMR writes SHALL affect only IMR[depth].
REQ-035 err SHALL be cleared only by W1C of CTRL bit1 or by reset.
REQ-036 Depth SHALL NOT wrap.
REQ-037 A strobe in the same cycle as ack SHALL be serviced normally; ack outside TRAP SHALL be ignored.

Reset
REQ-038 When reset_n=0 at a clock edge: ISR, MODE, every IMR entry, every ret entry, and depth SHALL be 0.
REQ-039 When reset_n=0 at a clock edge: FSM=IDLE; trap, vector, rdata, rvalid, halt, and err SHALL be 0; the irq history register SHALL be 0.
REQ-040 Reset mid-trap or mid-read SHALL abandon the operation with no output pulse afterwards.

Verification
REQ-041 The bench SHALL cover: MODE=1, IMR=0x4, pulse irq[2] one cycle -> trap=1, vector=2 within 3 cycles; hold until ack; trap=0 the cycle after ack.
REQ-042 The bench SHALL cover: IMR=0xFF, irq[5] and irq[1] edges together -> vector=1; W1C 0x2, push RA, ack -> second trap with vector=5.
REQ-043 The bench SHALL cover: push RA 0x1234 and 0x5678 (depth 2), then pop twice -> rdata 0x5678 then 0x1234, each with rvalid 1 cycle after strobe; IMR restored to its depth-0 value.
REQ-044 The bench SHALL cover: DEPTH_BITS=2, four pushes -> depth=3, err=1, and a pop returns the third pushed value; an extra pop at depth 0 -> rdata 0, err=1.
REQ-045 The bench SHALL cover: level-mode irq[0] held high with W1C of ISR bit0 -> ISR bit0 still 1 next cycle; drop irq[0] -> ISR bit0 = 0 two cycles later.
REQ-046 The bench SHALL cover: assert reset_n=0 while trap=1 -> trap=0, depth=0, and err=0 at the next edge; no trap afterwards until new pending.
